prioritet_scan: RTL and testbench

- Parametrised, sequential successor to the combinational 8-bit priority encoder.
- Accepts a WIDTH-bit request vector through a valid/ready handshake and latches it.
- Emits the indices of every set bit, highest first, one per output handshake.
- Used wherever all pending requests must be served in priority order, not only the top one.

---
 rtl/prioritet_scan.sv | 140 ++++++++++++++
 tb/tb_prioritet_scan.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prioritet_scan.sv
// prioritet_scan
//   Sequential priority scanner. It accepts a WIDTH-bit request vector
//   through a valid/ready handshake and latches it. It then emits the index
//   of every set bit, highest first, with one index per output handshake.
//
// Parameters
//   WIDTH  width of the request vector (must be >= 2)
//   IDX_W  derived index width, $clog2(WIDTH)
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   number is valid this cycle
//   in_ready   block accepts a vector this cycle
//   number     request vector, bit i set = request i pending
//   out_valid  ub holds a valid index
//   out_ready  consumer takes ub this cycle
//   ub         index of the highest still-pending bit
//   last       with out_valid: ub is the final index of the current vector
//   err_zero   one-cycle pulse: an all-zero vector was accepted and dropped
//   cnt        (PRIO_SCAN_CNT_EN only) pending bits remaining, ub included
//
// Optional feature macro: PRIO_SCAN_CNT_EN adds the cnt output and its
// popcount logic.
module prioritet_scan #(
  parameter int WIDTH = 8,
  localparam int IDX_W = $clog2(WIDTH)
`ifdef PRIO_SCAN_CNT_EN
  ,
  localparam int CNT_W = $clog2(WIDTH + 1)
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] number,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] ub,
  output logic             last,
  output logic             err_zero
`ifdef PRIO_SCAN_CNT_EN
  ,
  output logic [CNT_W-1:0] cnt
`endif
);

  typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] pend, pend_nxt;
  logic             err_nxt;
  logic             fire;
  logic             accept;

  // Index of the highest set bit. Later iterations overwrite earlier ones,
  // so the highest set bit wins.
  function automatic logic [IDX_W-1:0] top_idx(input logic [WIDTH-1:0] v);
    top_idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (v[i]) top_idx = i[IDX_W-1:0];
    end
  endfunction

  function automatic logic is_onehot(input logic [WIDTH-1:0] v);
    is_onehot = (v != '0) && ((v & (v - WIDTH'(1))) == '0);
  endfunction

`ifdef PRIO_SCAN_CNT_EN
  logic [CNT_W-1:0] cnt_nxt;

  function automatic logic [CNT_W-1:0] ones(input logic [WIDTH-1:0] v);
    ones = '0;
    for (int i = 0; i < WIDTH; i++) begin
      ones = ones + CNT_W'(v[i]);
    end
  endfunction
`endif

  // Outputs decode only registered state. pend is zero whenever the block
  // is idle, but the gating keeps ub/last at 0 outside SCAN regardless.
  // The path from out_ready to in_ready is deliberate: it lets the next
  // vector load in the same cycle that the final index is consumed.
  always_comb begin
    out_valid = (state == SCAN);
    ub        = out_valid ? top_idx(pend) : '0;
    last      = out_valid & is_onehot(pend);
    fire      = out_valid & out_ready;
    in_ready  = (state == IDLE) | (fire & last);
    accept    = in_valid & in_ready;

    state_nxt = state;
    pend_nxt  = pend;
    err_nxt   = 1'b0;

    if (fire) begin
      pend_nxt = pend & ~(WIDTH'(1) << ub);
      if (last) state_nxt = IDLE;
    end

    // An accept can only coincide with a fire on the last beat. In that
    // case the reload overrides the cleared pend, so there is no idle bubble.
    if (accept) begin
      if (number != '0) begin
        pend_nxt  = number;
        state_nxt = SCAN;
      end else begin
        state_nxt = IDLE;
        err_nxt   = 1'b1;
      end
    end
  end

`ifdef PRIO_SCAN_CNT_EN
  always_comb begin
    cnt_nxt = cnt;
    if (fire) cnt_nxt = cnt - CNT_W'(1);
    if (accept) cnt_nxt = (number != '0) ? ones(number) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else     cnt <= cnt_nxt;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      pend     <= '0;
      err_zero <= 1'b0;
    end else begin
      state    <= state_nxt;
      pend     <= pend_nxt;
      err_zero <= err_nxt;
    end
  end

endmodule

// File: tb/tb_prioritet_scan.sv
module tb_prioritet_scan;

  localparam int W  = 8;
  localparam int IW = $clog2(W);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  number = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [IW-1:0] ub;
  logic          last;
  logic          err_zero;

  logic          iv16 = 1'b0;
  logic          ir16;
  logic [15:0]   n16 = '0;
  logic          ov16;
  logic          or16 = 1'b0;
  logic [3:0]    ub16;
  logic          last16;
  logic          ez16;

`ifdef PRIO_SCAN_CNT_EN
  logic [3:0]    cnt;
  logic [4:0]    cnt16;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  prioritet_scan #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .number(number), .out_valid(out_valid), .out_ready(out_ready),
    .ub(ub), .last(last), .err_zero(err_zero)
`ifdef PRIO_SCAN_CNT_EN
    , .cnt(cnt)
`endif
  );

  prioritet_scan #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16),
    .number(n16), .out_valid(ov16), .out_ready(or16),
    .ub(ub16), .last(last16), .err_zero(ez16)
`ifdef PRIO_SCAN_CNT_EN
    , .cnt(cnt16)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Table of vectors: expected indices packed as nibbles, first beat in the
  // top nibble.
  typedef struct {
    logic [7:0]  num;
    int          n;
    logic [31:0] ubs;
  } vec_t;

  vec_t tv[6];

  // Reference model: queue of indices still to be emitted.
  int   q[$];
  logic err_exp;

  initial begin
    tv[0] = '{8'hA6, 4, 32'h7521_0000};
    tv[1] = '{8'h01, 1, 32'h0000_0000};
    tv[2] = '{8'h80, 1, 32'h7000_0000};
    tv[3] = '{8'hFF, 8, 32'h7654_3210};
    tv[4] = '{8'h00, 0, 32'h0000_0000};
    tv[5] = '{8'h41, 2, 32'h6000_0000};

    // Reset state
    #2;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_ub", 32'(ub), 0);
    chk("rst_last", 32'(last), 0);
    chk("rst_err_zero", 32'(err_zero), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    tick();
    rst = 1'b0;
    tick();

    // Table-driven vectors with out_ready held high
    for (int t = 0; t < 6; t++) begin
      number = tv[t].num; in_valid = 1'b1; out_ready = 1'b1;
      #1;
      chk("tbl_in_ready", 32'(in_ready), 1);
      tick();
      in_valid = 1'b0;
      #1;
      if (tv[t].n == 0) begin
        chk("tbl_err_pulse", 32'(err_zero), 1);
        chk("tbl_zero_valid", 32'(out_valid), 0);
        chk("tbl_zero_ready", 32'(in_ready), 1);
        tick(); #1;
        chk("tbl_err_clear", 32'(err_zero), 0);
      end else begin
        for (int k = 0; k < tv[t].n; k++) begin
          chk("tbl_valid", 32'(out_valid), 1);
          chk("tbl_ub", 32'(ub), 32'(tv[t].ubs[31-4*k -: 4]));
          chk("tbl_last", 32'(last), 32'(k == tv[t].n - 1));
          tick(); #1;
        end
      end
      chk("tbl_idle", 32'(out_valid), 0);
    end

    // Backpressure on the second beat
    number = 8'hA6; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0; #1;
    chk("bp_ub7", 32'(ub), 7);
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_hold_valid", 32'(out_valid), 1);
      chk("bp_hold_ub", 32'(ub), 5);
      chk("bp_hold_last", 32'(last), 0);
      chk("bp_hold_in_ready", 32'(in_ready), 0);
      tick();
    end
    out_ready = 1'b1; #1;
    chk("bp_ub5", 32'(ub), 5);
    tick(); #1;
    chk("bp_ub2", 32'(ub), 2);
    tick(); #1;
    chk("bp_ub1", 32'(ub), 1);
    chk("bp_last1", 32'(last), 1);
    tick(); #1;
    chk("bp_idle", 32'(out_valid), 0);

    // Back-to-back vectors, in_valid held
    number = 8'h01; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    number = 8'h80; #1;
    chk("b2b_ub0", 32'(ub), 0);
    chk("b2b_last0", 32'(last), 1);
    chk("b2b_in_ready", 32'(in_ready), 1);
    tick();
    in_valid = 1'b0; #1;
    chk("b2b_valid7", 32'(out_valid), 1);
    chk("b2b_ub7", 32'(ub), 7);
    chk("b2b_last7", 32'(last), 1);
    tick(); #1;
    chk("b2b_idle", 32'(out_valid), 0);

    // Asynchronous reset mid-scan
    number = 8'hFF; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0; #1;
    chk("ar_ub7", 32'(ub), 7);
    tick(); #1;
    chk("ar_ub6", 32'(ub), 6);
    tick(); #1;
    chk("ar_ub5", 32'(ub), 5);
    #1 rst = 1'b1;
    #1;
    chk("ar_valid_drop", 32'(out_valid), 0);
    chk("ar_ub_drop", 32'(ub), 0);
    chk("ar_last_drop", 32'(last), 0);
    tick();
    rst = 1'b0;
    tick(); #1;
    chk("ar_post_idle", 32'(out_valid), 0);
    number = 8'h04; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; #1;
    chk("ar_ub2", 32'(ub), 2);
    chk("ar_last2", 32'(last), 1);
    tick(); #1;
    chk("ar_done", 32'(out_valid), 0);

    // WIDTH=16 instance
    n16 = 16'h8001; iv16 = 1'b1; or16 = 1'b1;
    tick();
    iv16 = 1'b0; #1;
    chk("w16_ub15", 32'(ub16), 15);
    chk("w16_last15", 32'(last16), 0);
`ifdef PRIO_SCAN_CNT_EN
    chk("w16_cnt2", 32'(cnt16), 2);
`endif
    tick(); #1;
    chk("w16_ub0", 32'(ub16), 0);
    chk("w16_last0", 32'(last16), 1);
`ifdef PRIO_SCAN_CNT_EN
    chk("w16_cnt1", 32'(cnt16), 1);
`endif
    tick(); #1;
    chk("w16_idle", 32'(ov16), 0);

    // Randomized traffic against the queue model
    q.delete();
    err_exp = 1'b0;
    begin
      logic hold;
      logic mready, fire, acc;
      int   r;
      hold = 1'b0;
      for (int c = 0; c < 500; c++) begin
        if (!hold) begin
          in_valid = ($urandom_range(0, 2) != 0);
          r = $urandom_range(0, 7);
          if (r == 0)      number = '0;
          else if (r == 1) number = W'(1) << $urandom_range(0, W - 1);
          else             number = W'($urandom);
        end
        out_ready = ($urandom_range(0, 3) != 0);
        #1;
        mready = (q.size() == 0) || (out_ready && q.size() == 1);
        chk("rnd_out_valid", 32'(out_valid), 32'(q.size() > 0));
        chk("rnd_ub", 32'(ub), (q.size() > 0) ? 32'(q[0]) : 32'd0);
        chk("rnd_last", 32'(last), 32'(q.size() == 1));
        chk("rnd_in_ready", 32'(in_ready), 32'(mready));
        chk("rnd_err_zero", 32'(err_zero), 32'(err_exp));
`ifdef PRIO_SCAN_CNT_EN
        chk("rnd_cnt", 32'(cnt), 32'(q.size()));
`endif
        fire = (q.size() > 0) && out_ready;
        acc  = in_valid && mready;
        err_exp = 1'b0;
        if (fire) void'(q.pop_front());
        if (acc) begin
          if (number == '0) err_exp = 1'b1;
          else begin
            q.delete();
            for (int i = W - 1; i >= 0; i--) if (number[i]) q.push_back(i);
          end
        end
        hold = in_valid && !acc;
        tick();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
